// File: rtl/adder_share_pkg.sv
// Shared types and the round-robin pick helper for the adder-sharing arbiter.
package adder_share_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ID_W_MAX = 6;
  localparam int unsigned N_MAX    = 1 << ID_W_MAX;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [DATA_W-1:0]   c;
  } resp_t;

  typedef struct packed {
    logic                found;
    logic [ID_W_MAX-1:0] idx;
  } pick_t;

  // First set request after ptr, wrapping modulo n; n folds to a constant at each call site.
  function automatic pick_t rr_pick(input logic [N_MAX-1:0]    req,
                                    input logic [ID_W_MAX-1:0] ptr,
                                    input int unsigned         n);
    pick_t       p;
    int unsigned idx;
    p = '0;
    for (int unsigned k = 1; k <= N_MAX; k++) begin
      if (k <= n && !p.found) begin
        idx = (32'(ptr) + k) % n;
        if (req[idx[ID_W_MAX-1:0]]) begin
          p.found = 1'b1;
          p.idx   = idx[ID_W_MAX-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// Requester, adder and response signals of the adder-sharing arbiter.
interface adder_share_arb_if
  import adder_share_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
);
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*DATA_W-1:0] req_a;
  logic [N*DATA_W-1:0] req_b;
  logic [DATA_W-1:0]   add_a;
  logic [DATA_W-1:0]   add_b;
  logic                add_in_valid;
  logic [DATA_W-1:0]   add_c;
  logic                add_out_valid;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [DATA_W-1:0]   resp_c;

  modport slave (
    input  req_valid, req_a, req_b, add_c, add_out_valid, resp_ready,
    output req_ready, add_a, add_b, add_in_valid, resp_valid, resp_id, resp_c
  );

  modport master (
    output req_valid, req_a, req_b, add_c, add_out_valid, resp_ready,
    input  req_ready, add_a, add_b, add_in_valid, resp_valid, resp_id, resp_c
  );
endinterface

// File: rtl/adder_share_resp_fifo.sv
// Response FIFO; credits upstream keep it from ever being pushed while full.
module adder_share_resp_fifo
  import adder_share_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  resp_t data_i,
  input  logic  pop_i,
  output logic  valid_o,
  output resp_t head_o
);
  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  resp_t          mem_q [Depth];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic           do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid_o = (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= bump(wr_q);
      if (do_pop) rd_q <= bump(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_i |-> (cnt_q < CW'(Depth)));

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sharing of one tagless fixed-latency adder among N requesters.
// Optional stall counter: define ADDER_SHARE_ARB_STALL_CNT_EN.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ID_W    = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_share_arb_if.slave  bus
`ifdef ADDER_SHARE_ARB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic [LATENCY-1:0] tag_vld_q;
  logic [ID_W-1:0]    tag_id_q [LATENCY];

  pick_t           pick;
  logic            grant;
  logic [ID_W-1:0] win;
  logic            tail_vld, push, drop, pop, fifo_valid;
  resp_t           push_entry, head;
  logic            unused_bits;

  assign pick  = rr_pick(N_MAX'(bus.req_valid), ID_W_MAX'(ptr_q), N);
  assign grant = pick.found && (credit_q != '0);
  assign win   = pick.idx[ID_W-1:0];

  always_comb begin
    bus.req_ready = '0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant && win == ID_W'(i)) begin
        bus.req_ready[i] = 1'b1;
        bus.add_a        = bus.req_a[i*DATA_W +: DATA_W];
        bus.add_b        = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
    bus.add_in_valid = grant;
  end

  // A tag without a matching adder strobe is dropped and its credit handed back.
  assign tail_vld = tag_vld_q[LATENCY-1];
  assign push     = tail_vld && bus.add_out_valid;
  assign drop     = tail_vld && !bus.add_out_valid;
  assign pop      = fifo_valid && bus.resp_ready;

  assign ptr_d    = grant ? win : ptr_q;
  assign credit_d = credit_q - CW'(grant) + CW'(pop) + CW'(drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= ID_W'(N - 1);
      credit_q  <= CW'(DEPTH);
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      credit_q     <= credit_d;
      tag_vld_q[0] <= grant;
      tag_id_q[0]  <= win;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign push_entry = '{id: ID_W_MAX'(tag_id_q[LATENCY-1]), c: bus.add_c};

  adder_share_resp_fifo #(
    .Depth (DEPTH)
  ) u_resp_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .head_o  (head)
  );

  assign bus.resp_valid = fifo_valid;
  assign bus.resp_id    = head.id[ID_W-1:0];
  assign bus.resp_c     = head.c;
  assign unused_bits    = ^{pick.idx, head.id};

`ifdef ADDER_SHARE_ARB_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (|bus.req_valid && credit_q == '0 && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cnt = stall_q;
`endif

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credit_q <= CW'(DEPTH));

endmodule

// File: tb/tb_adder_share_arb.sv
// Randomised bench for adder_share_arb against a queue-based reference model.
module tb_adder_share_arb;
  localparam int N       = 4;
  localparam int LATENCY = 1;
  localparam int DEPTH   = 4;
  localparam int ID_W    = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inj_vld = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  adder_share_arb_if #(.N(N), .ID_W(ID_W)) bus ();

`ifdef ADDER_SHARE_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  adder_share_arb #(
    .N       (N),
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .ID_W    (ID_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ADDER_SHARE_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // External adder: fixed latency, no tag, no reset (stale output survives a DUT reset).
  logic [LATENCY-1:0] ad_vld_q = '0;
  logic [31:0]        ad_c_q [LATENCY];
  always @(posedge clk) begin
    ad_vld_q[0] <= bus.add_in_valid;
    ad_c_q[0]   <= bus.add_a + bus.add_b;
    for (int i = 1; i < LATENCY; i++) begin
      ad_vld_q[i] <= ad_vld_q[i-1];
      ad_c_q[i]   <= ad_c_q[i-1];
    end
  end
  assign bus.add_out_valid = ad_vld_q[LATENCY-1] | inj_vld;
  assign bus.add_c         = ad_c_q[LATENCY-1];

  // Reference model: who should win, and which results appear when.
  typedef struct { int id; logic [31:0] c; int avail; } exp_t;
  exp_t m_q[$];
  int   m_ptr = N - 1;
  int   m_credits = DEPTH;
  int   cyc = 0;

  function automatic int exp_winner();
    if (m_credits == 0) return -1;
    for (int k = 1; k <= N; k++) begin
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (exp_winner() >= 0) r[exp_winner()] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_op(input bit is_b);
    if (exp_winner() < 0) return 32'd0;
    return is_b ? bus.req_b[exp_winner()*32 +: 32] : bus.req_a[exp_winner()*32 +: 32];
  endfunction

  function automatic bit exp_rv();
    return (m_q.size() > 0) && (m_q[0].avail <= cyc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr     <= N - 1;
      m_credits <= DEPTH;
      cyc       <= 0;
      m_q.delete();
    end else begin
      m_credits <= m_credits - ((exp_winner() >= 0) ? 1 : 0) + ((exp_rv() && bus.resp_ready) ? 1 : 0);
      if (exp_winner() >= 0) m_ptr <= exp_winner();
      if (exp_rv() && bus.resp_ready) void'(m_q.pop_front());
      if (exp_winner() >= 0)
        m_q.push_back('{id: exp_winner(), c: exp_op(0) + exp_op(1), avail: cyc + LATENCY + 1});
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_checks += 5;
      if (bus.req_ready !== exp_ready()) begin
        n_errors++;
        $display("FAIL mon_req_ready t=%0t got=%b exp=%b", $time, bus.req_ready, exp_ready());
      end
      if (bus.add_in_valid !== (|exp_ready())) begin
        n_errors++;
        $display("FAIL mon_add_in_valid t=%0t got=%b exp=%b", $time, bus.add_in_valid, |exp_ready());
      end
      if (bus.add_a !== exp_op(0)) begin
        n_errors++;
        $display("FAIL mon_add_a t=%0t got=%h exp=%h", $time, bus.add_a, exp_op(0));
      end
      if (bus.add_b !== exp_op(1)) begin
        n_errors++;
        $display("FAIL mon_add_b t=%0t got=%h exp=%h", $time, bus.add_b, exp_op(1));
      end
      if (bus.resp_valid !== exp_rv()) begin
        n_errors++;
        $display("FAIL mon_resp_valid t=%0t got=%b exp=%b", $time, bus.resp_valid, exp_rv());
      end
      if (exp_rv()) begin
        n_checks += 2;
        if (bus.resp_id !== ID_W'(m_q[0].id)) begin
          n_errors++;
          $display("FAIL mon_resp_id t=%0t got=%0d exp=%0d", $time, bus.resp_id, m_q[0].id);
        end
        if (bus.resp_c !== m_q[0].c) begin
          n_errors++;
          $display("FAIL mon_resp_c t=%0t got=%h exp=%h", $time, bus.resp_c, m_q[0].c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*32 +: 32] = $urandom;
      bus.req_b[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic drain();
    int k;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    k = 0;
    while (m_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    n_checks++;
    if (m_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout left=%0d exp=0", m_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 3;
    if (bus.resp_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid);
    end
    if (bus.add_in_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_add_in_valid got=%b exp=0", bus.add_in_valid);
    end
    if (bus.add_a !== 32'd0) begin
      n_errors++; $display("FAIL reset_add_a got=%h exp=0", bus.add_a);
    end
`ifdef ADDER_SHARE_ARB_STALL_CNT_EN
    n_checks++;
    if (stall_cnt !== 32'd0) begin
      n_errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = '1;
    randomize_ops();
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_errors++; $display("FAIL reset_first_priority got=%b exp=0001", bus.req_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_single();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b0001;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_a[31:0] = 32'd5;
    bus.req_b[31:0] = 32'd7;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_errors++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_errors++; $display("FAIL single_early_resp got=%b exp=0", bus.resp_valid);
    end
    tick();
    @(negedge clk);
    n_checks += 3;
    if (bus.resp_valid !== 1'b1) begin
      n_errors++; $display("FAIL single_resp_valid got=%b exp=1", bus.resp_valid);
    end
    if (bus.resp_id !== 2'd0) begin
      n_errors++; $display("FAIL single_resp_id got=%0d exp=0", bus.resp_id);
    end
    if (bus.resp_c !== 32'd12) begin
      n_errors++; $display("FAIL single_resp_c got=%0d exp=12", bus.resp_c);
    end
    tick();
    drain();
  endtask

  task automatic test_rr();
    int start;
    logic [N-1:0] want;
    start = (m_ptr + 1) % N;
    bus.resp_ready = 1'b1;
    bus.req_valid  = '1;
    for (int k = 0; k < 12; k++) begin
      randomize_ops();
      want = '0;
      want[(start + k) % N] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== want) begin
        n_errors++; $display("FAIL rr_order k=%0d got=%b exp=%b", k, bus.req_ready, want);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_credit_stall();
    int gnt;
`ifdef ADDER_SHARE_ARB_STALL_CNT_EN
    logic [31:0] st0;
`endif
    gnt = 0;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b0010;
    randomize_ops();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
`ifdef ADDER_SHARE_ARB_STALL_CNT_EN
      if (k == 0) st0 = stall_cnt;
`endif
      if (bus.req_ready[1]) gnt++;
      if (k >= DEPTH) begin
        n_checks++;
        if (bus.req_ready !== '0) begin
          n_errors++; $display("FAIL stall_over_grant k=%0d got=%b exp=0000", k, bus.req_ready);
        end
      end
      tick();
    end
    n_checks++;
    if (gnt != DEPTH) begin
      n_errors++; $display("FAIL stall_grant_count got=%0d exp=%0d", gnt, DEPTH);
    end
`ifdef ADDER_SHARE_ARB_STALL_CNT_EN
    @(negedge clk);
    n_checks++;
    if (stall_cnt - st0 !== 32'(10 - DEPTH)) begin
      n_errors++; $display("FAIL stall_cnt_delta got=%0d exp=%0d", stall_cnt - st0, 10 - DEPTH);
    end
`endif
    tick();
    bus.resp_ready = 1'b1;
    gnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req_ready[1]) gnt++;
      tick();
    end
    n_checks++;
    if (gnt != 7) begin
      n_errors++; $display("FAIL stall_resume_grants got=%0d exp=7", gnt);
    end
    drain();
  endtask

  task automatic test_wrap();
    int k;
    bus.resp_ready = 1'b1;
    randomize_ops();
    bus.req_a[3*32 +: 32] = 32'hFFFF_FFFF;
    bus.req_b[3*32 +: 32] = 32'h2;
    bus.req_valid = 4'b1000;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b1000) begin
      n_errors++; $display("FAIL wrap_grant3 got=%b exp=1000", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b1001;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_errors++; $display("FAIL wrap_next_is_0 got=%b exp=0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    k = 0;
    @(negedge clk);
    while (!bus.resp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_checks += 2;
    if (bus.resp_id !== 2'd3 || !bus.resp_valid) begin
      n_errors++; $display("FAIL wrap_resp_id got=%0d valid=%b exp=3", bus.resp_id, bus.resp_valid);
    end
    if (bus.resp_c !== 32'h1) begin
      n_errors++; $display("FAIL wrap_resp_c got=%h exp=00000001", bus.resp_c);
    end
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    int gnt;
    bus.resp_ready = 1'b0;
    bus.req_valid  = '1;
    randomize_ops();
    repeat (3) tick();
    rst_n = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_in_reset got=%b exp=0", bus.resp_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    inj_vld = 1'b1;
    tick();
    inj_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b0) begin
        n_errors++; $display("FAIL rstmid_stale k=%0d got=%b exp=0", k, bus.resp_valid);
      end
      tick();
    end
    bus.req_valid = '1;
    gnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
          n_errors++; $display("FAIL rstmid_immediate got=%b exp=0001", bus.req_ready);
        end
      end
      if (bus.add_in_valid) gnt++;
      tick();
    end
    n_checks++;
    if (gnt != DEPTH) begin
      n_errors++; $display("FAIL rstmid_credits got=%0d exp=%0d", gnt, DEPTH);
    end
    drain();
  endtask

  task automatic test_grant_pop();
    int outst;
    outst = 0;
    for (int k = 0; k < 28; k++) begin
      if (k < 3) begin
        bus.req_valid = '1; bus.resp_ready = 1'b0;
      end else if (k < 6) begin
        bus.req_valid = '0; bus.resp_ready = 1'b0;
      end else if (k < 8) begin
        bus.req_valid = '1; bus.resp_ready = 1'b1;
      end else begin
        bus.req_valid  = N'($urandom);
        bus.resp_ready = 1'($urandom);
      end
      randomize_ops();
      @(negedge clk);
      if (k == 6 || k == 7) begin
        n_checks += 2;
        if (bus.add_in_valid !== 1'b1) begin
          n_errors++; $display("FAIL gp_grant k=%0d got=%b exp=1", k, bus.add_in_valid);
        end
        if (bus.resp_valid !== 1'b1) begin
          n_errors++; $display("FAIL gp_pop k=%0d got=%b exp=1", k, bus.resp_valid);
        end
      end
      outst += (bus.add_in_valid ? 1 : 0) - ((bus.resp_valid && bus.resp_ready) ? 1 : 0);
      n_checks++;
      if (outst > DEPTH) begin
        n_errors++; $display("FAIL gp_bound k=%0d got=%0d exp<=%0d", k, outst, DEPTH);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_credit_stall();
    test_wrap();
    test_reset_mid();
    test_grant_pop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
